npu_stream_sequencer: RTL and testbench

NPU_STREAM_SEQUENCER -- requirements
Module: npu_stream_sequencer

---
 rtl/npu_stream_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_npu_stream_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_stream_sequencer.sv
// npu_stream_sequencer
// Sequences one matrix job through a systolic core. Operands A and B are
// loaded into local N x N buffers while idle. A command starts the job; each
// run streams N operand beats, optionally separated by idle gaps, waits for
// the core to finish, and then drains the results to the output stream.
// A command may request several runs over the same operands.
//
// Build option: define SEQ_TIMEOUT_EN to add a watchdog on the WAIT state.
// The watchdog adds an ERROR state and drives a sticky err_timeout flag.
// Without it, WAIT has no time limit and err_timeout is tied low.
module npu_stream_sequencer #(
    parameter int ARRAY_SIZE     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 22,
    parameter int RUN_WIDTH      = 8,
    parameter int GAP_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    // operand buffer write port
    input  logic                                      op_wr_en,
    input  logic                                      op_wr_sel,
    input  logic [$clog2(ARRAY_SIZE*ARRAY_SIZE)-1:0]  op_wr_addr,
    input  logic [DATA_WIDTH-1:0]                     op_wr_data,
    // job command
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [RUN_WIDTH-1:0]                      cmd_repeat,
    input  logic [GAP_WIDTH-1:0]                      cmd_gap,
    // core control and operand lanes
    output logic                                      core_start,
    output logic                                      core_in_valid,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]          core_a_stream,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]          core_b_stream,
    input  logic                                      core_c_valid,
    // core result drain
    input  logic                                      core_result_valid,
    input  logic [ACC_WIDTH-1:0]                      core_result_data,
    input  logic [$clog2(ARRAY_SIZE*ARRAY_SIZE)-1:0]  core_result_index,
    output logic                                      core_result_ready,
    // result stream
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ACC_WIDTH-1:0]                      out_data,
    output logic [$clog2(ARRAY_SIZE*ARRAY_SIZE)-1:0]  out_index,
    output logic [RUN_WIDTH-1:0]                      out_run,
    output logic                                      out_last,
    // status
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err_timeout
);

    localparam int N       = ARRAY_SIZE;
    localparam int ELEMS   = N * N;
    localparam int IDX_W   = $clog2(ELEMS);
    localparam int BEAT_W  = $clog2(N);
    localparam int LANES_W = N * DATA_WIDTH;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(ELEMS - 1);

    // Elaboration-time parameter sanity checks
    if (ARRAY_SIZE < 2) begin : g_bad_array_size
        $error("npu_stream_sequencer: ARRAY_SIZE must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("npu_stream_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STREAM, S_GAP, S_WAIT, S_DRAIN, S_ERROR
    } state_t;

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STREAM, S_GAP, S_WAIT, S_DRAIN
    } state_t;
`endif

    state_t state;

    // operand buffers, row-major
    logic [DATA_WIDTH-1:0] a_mem [ELEMS];
    logic [DATA_WIDTH-1:0] b_mem [ELEMS];

    // job registers
    logic [RUN_WIDTH-1:0] run_cnt;
    logic [RUN_WIDTH-1:0] repeat_reg;
    logic [GAP_WIDTH-1:0] gap_reg;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [BEAT_W-1:0]    beat;

    // lane values for the beat about to be loaded into the stream registers
    logic [BEAT_W-1:0]    sel;
    logic [LANES_W-1:0]   a_lanes;
    logic [LANES_W-1:0]   b_lanes;

    logic                 in_drain;
    logic                 last_hs;
    logic                 more_runs;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_run   = run_cnt;

    // Gather lane values: lane r carries A[r][k] and B[k][r] for beat k.
    // While streaming, the beat counter names the beat currently on the
    // lanes, so the next one is beat+1; from START or GAP it is beat itself.
    always_comb begin
        sel     = beat;
        a_lanes = '0;
        b_lanes = '0;
        if (state == S_STREAM && beat != LAST_BEAT) begin
            sel = beat + 1'b1;
        end
        for (int unsigned r = 0; r < N; r++) begin
            a_lanes[r*DATA_WIDTH +: DATA_WIDTH] = a_mem[IDX_W'(r * N + sel)];
            b_lanes[r*DATA_WIDTH +: DATA_WIDTH] = b_mem[IDX_W'(sel * N + r)];
        end
    end

    // Result path is a pure pass-through while draining, closed otherwise
    always_comb begin
        in_drain          = (state == S_DRAIN);
        out_valid         = in_drain & core_result_valid;
        core_result_ready = in_drain & out_ready;
        out_data          = in_drain ? core_result_data  : '0;
        out_index         = in_drain ? core_result_index : '0;
        out_last          = in_drain & (core_result_index == LAST_IDX);
        last_hs           = out_valid & out_ready & out_last;
        more_runs         = ({1'b0, run_cnt} + 1'b1) < {1'b0, repeat_reg};
    end

    // Sequencer FSM with registered core controls, lanes and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            a_mem         <= '{default: '0};
            b_mem         <= '{default: '0};
            run_cnt       <= '0;
            repeat_reg    <= '0;
            gap_reg       <= '0;
            gap_cnt       <= '0;
            beat          <= '0;
            core_start    <= 1'b0;
            core_in_valid <= 1'b0;
            core_a_stream <= '0;
            core_b_stream <= '0;
            done          <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt      <= '0;
            err_timeout   <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_wr_en) begin
                        if (op_wr_sel) b_mem[op_wr_addr] <= op_wr_data;
                        else           a_mem[op_wr_addr] <= op_wr_data;
                    end
                    if (cmd_valid) begin
                        repeat_reg <= (cmd_repeat == '0) ? RUN_WIDTH'(1) : cmd_repeat;
                        gap_reg    <= cmd_gap;
                        run_cnt    <= '0;
                        beat       <= '0;
                        core_start <= 1'b1;
                        state      <= S_START;
`ifdef SEQ_TIMEOUT_EN
                        err_timeout <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    core_in_valid <= 1'b1;
                    core_a_stream <= a_lanes;
                    core_b_stream <= b_lanes;
                    state         <= S_STREAM;
                end
                S_STREAM: begin
                    if (beat == LAST_BEAT) begin
                        core_in_valid <= 1'b0;
                        core_a_stream <= '0;
                        core_b_stream <= '0;
                        state         <= S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end else if (gap_reg == '0) begin
                        beat          <= beat + 1'b1;
                        core_a_stream <= a_lanes;
                        core_b_stream <= b_lanes;
                    end else begin
                        beat          <= beat + 1'b1;
                        gap_cnt       <= gap_reg - 1'b1;
                        core_in_valid <= 1'b0;
                        core_a_stream <= '0;
                        core_b_stream <= '0;
                        state         <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        core_in_valid <= 1'b1;
                        core_a_stream <= a_lanes;
                        core_b_stream <= b_lanes;
                        state         <= S_STREAM;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (core_c_valid) begin
                        state <= S_DRAIN;
`ifdef SEQ_TIMEOUT_EN
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        err_timeout <= 1'b1;
                        state       <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_DRAIN: begin
                    if (last_hs) begin
                        if (more_runs) begin
                            run_cnt    <= run_cnt + 1'b1;
                            beat       <= '0;
                            core_start <= 1'b1;
                            state      <= S_START;
                        end else begin
                            run_cnt <= '0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                S_ERROR: begin
                    state <= S_IDLE;
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SEQ_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_npu_stream_sequencer.sv
// Testbench for npu_stream_sequencer. A behavioural core model consumes the
// operand beats and returns their matrix product; expected results come from
// a plain matrix multiply of the bench's own copy of A and B and are queued
// per command, then popped by an independent output monitor.
// The timeout scenario runs only when SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_npu_stream_sequencer;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AW    = 22;
    localparam int RW    = 8;
    localparam int GW    = 4;
    localparam int TO    = 64;
    localparam int ELEMS = N * N;
    localparam int IW    = $clog2(ELEMS);

    logic              clk;
    logic              rst_n;
    logic              op_wr_en;
    logic              op_wr_sel;
    logic [IW-1:0]     op_wr_addr;
    logic [DW-1:0]     op_wr_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [RW-1:0]     cmd_repeat;
    logic [GW-1:0]     cmd_gap;
    logic              core_start;
    logic              core_in_valid;
    logic [N*DW-1:0]   core_a_stream;
    logic [N*DW-1:0]   core_b_stream;
    logic              core_c_valid;
    logic              core_result_valid;
    logic [AW-1:0]     core_result_data;
    logic [IW-1:0]     core_result_index;
    logic              core_result_ready;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_data;
    logic [IW-1:0]     out_index;
    logic [RW-1:0]     out_run;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err_timeout;

    npu_stream_sequencer #(
        .ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
        .RUN_WIDTH(RW), .GAP_WIDTH(GW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .op_wr_en(op_wr_en), .op_wr_sel(op_wr_sel),
        .op_wr_addr(op_wr_addr), .op_wr_data(op_wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_repeat(cmd_repeat), .cmd_gap(cmd_gap),
        .core_start(core_start), .core_in_valid(core_in_valid),
        .core_a_stream(core_a_stream), .core_b_stream(core_b_stream),
        .core_c_valid(core_c_valid),
        .core_result_valid(core_result_valid), .core_result_data(core_result_data),
        .core_result_index(core_result_index), .core_result_ready(core_result_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_run(out_run), .out_last(out_last),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int compared   = 0;
    int mismatched = 0;
    int start_cnt  = 0;
    int done_cnt   = 0;
    int rdy_mode   = 2;     // 0 random, 1 toggle, 2 always ready
    bit core_mute  = 1'b0;  // core never reports completion

    int ref_a [ELEMS];
    int ref_b [ELEMS];

    typedef struct {
        longint data;
        longint index;
        longint run;
        longint last;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input longint act);
        compared++;
        mismatched++;
        $display("FAIL %s: actual %0d required event not seen (t=%0t)", name, act, $time);
    endtask

    function automatic longint ref_c(input int idx);
        longint s = 0;
        int r = idx / N;
        int c = idx % N;
        for (int k = 0; k < N; k++) s += longint'(ref_a[r*N + k]) * longint'(ref_b[k*N + c]);
        return s;
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) start_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output", longint'(out_index));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data",  longint'($signed(out_data)), mon_e.data);
                    check("out_index", longint'(out_index), mon_e.index);
                    check("out_run",   longint'(out_run),   mon_e.run);
                    check("out_last",  longint'(out_last),  mon_e.last);
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = ~out_ready;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- behavioural core model ----------------
    int ca [N][N];
    int cb [N][N];
    int cres [ELEMS];
    int beats = 0;
    int dly   = 0;
    int ridx  = 0;
    bit pend  = 1'b0;
    bit pres  = 1'b0;

    initial begin
        core_c_valid      = 1'b0;
        core_result_valid = 1'b0;
        core_result_data  = '0;
        core_result_index = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                beats = 0; pend = 1'b0; pres = 1'b0; ridx = 0;
            end else begin
                if (core_start) begin
                    beats = 0; pend = 1'b0;
                end
                if (core_in_valid && beats < N) begin
                    for (int r = 0; r < N; r++) begin
                        ca[r][beats] = int'($signed(core_a_stream[r*DW +: DW]));
                        cb[beats][r] = int'($signed(core_b_stream[r*DW +: DW]));
                    end
                    beats++;
                    if (beats == N) begin
                        pend = 1'b1;
                        dly  = int'($urandom_range(0, 4));
                    end
                end
                if (core_result_valid && core_result_ready) begin
                    ridx++;
                    if (ridx == ELEMS) pres = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            core_c_valid = 1'b0;
            if (pend && !core_mute) begin
                if (dly == 0) begin
                    core_c_valid = 1'b1;
                    pend = 1'b0;
                    pres = 1'b1;
                    ridx = 0;
                    for (int i = 0; i < ELEMS; i++) begin
                        cres[i] = 0;
                        for (int k = 0; k < N; k++) cres[i] += ca[i/N][k] * cb[k][i%N];
                    end
                end else begin
                    dly--;
                end
            end
            core_result_valid = pres && ($urandom_range(0, 3) != 0);
            core_result_index = pres ? IW'(ridx) : '0;
            core_result_data  = pres ? AW'(cres[ridx]) : '0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input bit sel, input int addr, input int data);
        op_wr_en   = 1'b1;
        op_wr_sel  = sel;
        op_wr_addr = IW'(addr);
        op_wr_data = DW'(data);
        @(posedge clk);
        #1;
        op_wr_en = 1'b0;
    endtask

    task automatic load_mats();
        for (int i = 0; i < ELEMS; i++) begin
            wr(1'b0, i, ref_a[i]);
            wr(1'b1, i, ref_b[i]);
        end
    endtask

    task automatic rand_mats();
        for (int i = 0; i < ELEMS; i++) begin
            ref_a[i] = int'($urandom_range(0, 255)) - 128;
            ref_b[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic issue(input int rep, input int gap);
        cmd_repeat = RW'(rep);
        cmd_gap    = GW'(gap);
        cmd_valid  = 1'b1;
        @(negedge clk);
        check("cmd_ready_idle", longint'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input int rep, input int gap, input int mode, input bit pat);
        int eff;
        int s0;
        int d0;
        int cyc;
        int k;
        logic [N*DW-1:0] ea;
        logic [N*DW-1:0] eb;
        eff = (rep == 0) ? 1 : rep;
        for (int run = 0; run < eff; run++) begin
            for (int i = 0; i < ELEMS; i++) begin
                exp_q.push_back('{ref_c(i), longint'(i), longint'(run), longint'(i == ELEMS-1)});
            end
        end
        s0 = start_cnt;
        d0 = done_cnt;
        rdy_mode = mode;
        issue(rep, gap);
        if (pat) begin
            @(negedge clk);
            check("core_start_T+1", longint'(core_start), 1);
            check("no_beat_T+1", longint'(core_in_valid), 0);
            for (int j = 0; j <= (N-1)*(gap+1); j++) begin
                @(negedge clk);
                ea = '0;
                eb = '0;
                if (j % (gap+1) == 0) begin
                    k = j / (gap+1);
                    for (int r = 0; r < N; r++) begin
                        ea[r*DW +: DW] = DW'(ref_a[r*N + k]);
                        eb[r*DW +: DW] = DW'(ref_b[k*N + r]);
                    end
                end
                check("in_valid_pattern", longint'(core_in_valid), longint'(j % (gap+1) == 0));
                check("a_lanes", longint'(core_a_stream), longint'(ea));
                check("b_lanes", longint'(core_b_stream), longint'(eb));
            end
            @(negedge clk);
            check("in_valid_after_last", longint'(core_in_valid), 0);
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            op_wr_en   = busy;  // writes while busy must be ignored
            op_wr_sel  = 1'($urandom_range(0, 1));
            op_wr_addr = IW'($urandom_range(0, ELEMS-1));
            op_wr_data = DW'($urandom_range(0, 255));
            cyc++;
        end
        op_wr_en = 1'b0;
        if (done_cnt == d0) begin
            fail_now("done_timeout", cyc);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        check("start_pulses", start_cnt - s0, eff);
        check("done_pulses", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("idle_after_done", longint'(busy), 0);
        check("err_timeout_low", longint'(err_timeout), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_core_start", longint'(core_start), 0);
        check("rst_in_valid", longint'(core_in_valid), 0);
        check("rst_a_stream", longint'(core_a_stream), 0);
        check("rst_b_stream", longint'(core_b_stream), 0);
        check("rst_result_ready", longint'(core_result_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_last", longint'(out_last), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_err_timeout", longint'(err_timeout), 0);
    endtask

    task automatic reset_mid_job();
        int d0;
        int seen;
        int cyc;
        d0 = done_cnt;
        seen = 0;
        cyc = 0;
        rdy_mode = 2;
        issue(1, 0);
        while (seen < 3 && cyc < 50) begin
            @(negedge clk);
            if (core_in_valid) seen++;
            cyc++;
        end
        if (seen < 3) fail_now("beat2_not_reached", seen);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        check("rst_cmd_ready", longint'(cmd_ready), 1);
        exp_q.delete();
        for (int i = 0; i < ELEMS; i++) begin
            ref_a[i] = 0;
            ref_b[i] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);
        check("idle_after_reset", longint'(busy), 0);
        @(posedge clk);
        #1;
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic timeout_job();
        int d0;
        int err_at;
        int idle_at;
        d0 = done_cnt;
        err_at = -1;
        idle_at = -1;
        core_mute = 1'b1;
        rdy_mode = 2;
        issue(1, 0);
        for (int cyc = 1; cyc <= 300 && idle_at < 0; cyc++) begin
            @(negedge clk);
            if (err_timeout && err_at < 0) err_at = cyc;
            if (!busy && idle_at < 0) idle_at = cyc;
        end
        check("err_timeout_cycle", err_at, 2 + N + TO);
        check("idle_after_error", idle_at, 3 + N + TO);
        repeat (5) @(negedge clk);
        check("err_timeout_sticky", longint'(err_timeout), 1);
        check("no_done_on_timeout", done_cnt - d0, 0);
        core_mute = 1'b0;
        @(posedge clk);
        #1;
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        op_wr_en   = 1'b0;
        op_wr_sel  = 1'b0;
        op_wr_addr = '0;
        op_wr_data = '0;
        cmd_valid  = 1'b0;
        cmd_repeat = '0;
        cmd_gap    = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", longint'(cmd_ready), 1);
        @(posedge clk);
        #1;

        // identity A, B = 1..16: results 1..16, back-to-back beats
        for (int i = 0; i < ELEMS; i++) begin
            ref_a[i] = (i / N == i % N) ? 1 : 0;
            ref_b[i] = i + 1;
        end
        load_mats();
        run_job(1, 0, 2, 1'b1);
        // same operands with a 3-cycle gap between beats
        run_job(1, 3, 2, 1'b1);
        // three runs over random operands
        rand_mats();
        load_mats();
        run_job(3, 1, 0, 1'b1);
        // out_ready toggling every cycle during drain
        run_job(1, 0, 1, 1'b1);
        // repeat of zero behaves as one run
        run_job(0, 2, 0, 1'b1);
        // randomized jobs
        for (int t = 0; t < 6; t++) begin
            rand_mats();
            load_mats();
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 2)), 1'b1);
        end
        // reset in the middle of streaming; buffers come back cleared
        rand_mats();
        load_mats();
        reset_mid_job();
        run_job(1, 0, 2, 1'b1);
        // operand writes work again after reset
        rand_mats();
        load_mats();
        run_job(2, 1, 0, 1'b1);
`ifdef SEQ_TIMEOUT_EN
        timeout_job();
        run_job(1, 0, 2, 1'b1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
